// File: rtl/writeback_unit_if.sv
// Register-file write-side bundle: pipeline and MDU result handshakes, MDU issue
// notifications, the two write ports and the pending-destination mask.
interface writeback_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              pipe_valid;
  logic              pipe_ready;
  logic              pipe_dual;
  logic [ADDR_W-1:0] pipe_rd1;
  logic [ADDR_W-1:0] pipe_rd2;
  logic [DATA_W-1:0] pipe_data1;
  logic [DATA_W-1:0] pipe_data2;

  logic              mdu_valid;
  logic              mdu_ready;
  logic              mdu_dual;
  logic [ADDR_W-1:0] mdu_rd1;
  logic [ADDR_W-1:0] mdu_rd2;
  logic [DATA_W-1:0] mdu_data1;
  logic [DATA_W-1:0] mdu_data2;

  logic              mdu_issue;
  logic              mdu_issue_dual;
  logic [ADDR_W-1:0] mdu_issue_rd1;
  logic [ADDR_W-1:0] mdu_issue_rd2;

  logic              reg_write;
  logic              write_op2;
  logic [ADDR_W-1:0] write_reg1;
  logic [ADDR_W-1:0] write_reg2;
  logic [DATA_W-1:0] write_data1;
  logic [DATA_W-1:0] write_data2;

  logic [(2**ADDR_W)-1:0] pending_mask;

  modport master (
    output pipe_valid, pipe_dual, pipe_rd1, pipe_rd2, pipe_data1, pipe_data2,
    output mdu_valid, mdu_dual, mdu_rd1, mdu_rd2, mdu_data1, mdu_data2,
    output mdu_issue, mdu_issue_dual, mdu_issue_rd1, mdu_issue_rd2,
    input  pipe_ready, mdu_ready,
    input  reg_write, write_op2, write_reg1, write_reg2, write_data1, write_data2,
    input  pending_mask
  );

  modport slave (
    input  pipe_valid, pipe_dual, pipe_rd1, pipe_rd2, pipe_data1, pipe_data2,
    input  mdu_valid, mdu_dual, mdu_rd1, mdu_rd2, mdu_data1, mdu_data2,
    input  mdu_issue, mdu_issue_dual, mdu_issue_rd1, mdu_issue_rd2,
    output pipe_ready, mdu_ready,
    output reg_write, write_op2, write_reg1, write_reg2, write_data1, write_data2,
    output pending_mask
  );
endinterface

// File: rtl/writeback_unit.sv
// Merges WB-stage and buffered MDU results onto the register file write ports,
// with a starvation guard for the MDU and a pending-destination scoreboard.
module writeback_unit #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  writeback_unit_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREG  = 2 ** ADDR_W;

  typedef struct packed {
    logic              dual;
    logic [ADDR_W-1:0] rd1;
    logic [ADDR_W-1:0] rd2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  stv_q, stv_d;

  logic              reg_write_q, reg_write_d;
  logic              write_op2_q, write_op2_d;
  logic              src_mdu_q, src_mdu_d;
  logic [ADDR_W-1:0] write_reg1_q, write_reg1_d;
  logic [ADDR_W-1:0] write_reg2_q, write_reg2_d;
  logic [DATA_W-1:0] write_data1_q, write_data1_d;
  logic [DATA_W-1:0] write_data2_q, write_data2_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic   empty, full, starve;
  logic   pipe_ready_int, mdu_ready_int;
  logic   grant_pipe, grant_fifo, enq;
  logic [NREG-1:0] set_vec, clr_vec;
  entry_t pipe_e, mdu_e, sel_e;

  assign pipe_e = '{dual: bus.pipe_dual, rd1: bus.pipe_rd1, rd2: bus.pipe_rd2,
                    data1: bus.pipe_data1, data2: bus.pipe_data2};
  assign mdu_e  = '{dual: bus.mdu_dual, rd1: bus.mdu_rd1, rd2: bus.mdu_rd2,
                    data1: bus.mdu_data1, data2: bus.mdu_data2};

  // Arbitration uses only registered state, so both readies are stable in-cycle.
  assign empty          = (cnt_q == CNT_W'(0));
  assign full           = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign starve         = !empty && (stv_q >= STV_W'(STARVE_LIMIT));
  assign pipe_ready_int = rst && !starve;
  assign mdu_ready_int  = rst && !full;
  assign grant_pipe     = bus.pipe_valid && pipe_ready_int;
  assign grant_fifo     = rst && !grant_pipe && !empty;
  assign enq            = bus.mdu_valid && mdu_ready_int;
  assign sel_e          = grant_pipe ? pipe_e : fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_d         = cnt_q;
    stv_d         = stv_q;
    reg_write_d   = 1'b0;
    write_op2_d   = 1'b0;
    src_mdu_d     = 1'b0;
    write_reg1_d  = write_reg1_q;
    write_reg2_d  = write_reg2_q;
    write_data1_d = write_data1_q;
    write_data2_d = write_data2_q;
    set_vec       = '0;
    clr_vec       = '0;

    if (enq)        wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (grant_fifo) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, grant_fifo})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Count consecutive losses of a waiting MDU entry.
    if (empty || grant_fifo) begin
      stv_d = '0;
    end else if (grant_pipe && (stv_q < STV_W'(STARVE_LIMIT))) begin
      stv_d = stv_q + STV_W'(1);
    end

    if (grant_pipe || grant_fifo) begin
      reg_write_d   = 1'b1;
      write_op2_d   = sel_e.dual;
      src_mdu_d     = grant_fifo;
      write_reg1_d  = sel_e.rd1;
      write_reg2_d  = sel_e.rd2;
      write_data1_d = sel_e.data1;
      write_data2_d = sel_e.data2;
    end

    // Pending bits clear when the MDU write commits; a same-edge issue wins.
    if (reg_write_q && src_mdu_q) begin
      clr_vec[write_reg1_q] = 1'b1;
      if (write_op2_q) clr_vec[write_reg2_q] = 1'b1;
    end
    if (bus.mdu_issue) begin
      set_vec[bus.mdu_issue_rd1] = 1'b1;
      if (bus.mdu_issue_dual) set_vec[bus.mdu_issue_rd2] = 1'b1;
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      stv_q         <= '0;
      reg_write_q   <= 1'b0;
      write_op2_q   <= 1'b0;
      src_mdu_q     <= 1'b0;
      write_reg1_q  <= '0;
      write_reg2_q  <= '0;
      write_data1_q <= '0;
      write_data2_q <= '0;
      pending_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      stv_q         <= stv_d;
      reg_write_q   <= reg_write_d;
      write_op2_q   <= write_op2_d;
      src_mdu_q     <= src_mdu_d;
      write_reg1_q  <= write_reg1_d;
      write_reg2_q  <= write_reg2_d;
      write_data1_q <= write_data1_d;
      write_data2_q <= write_data2_d;
      pending_q     <= pending_d;
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr_q] <= mdu_e;
  end

  assign bus.pipe_ready   = pipe_ready_int;
  assign bus.mdu_ready    = mdu_ready_int;
  assign bus.reg_write    = reg_write_q;
  assign bus.write_op2    = write_op2_q;
  assign bus.write_reg1   = write_reg1_q;
  assign bus.write_reg2   = write_reg2_q;
  assign bus.write_data1  = write_data1_q;
  assign bus.write_data2  = write_data2_q;
  assign bus.pending_mask = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes queued at stimulus time,
// popped and compared whenever the DUT pulses reg_write.
module tb_writeback_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  writeback_unit_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  writeback_unit #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        dual;
    logic [3:0]  rd1;
    logic [3:0]  rd2;
    logic [15:0] d1;
    logic [15:0] d2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input bit v, input logic [3:0] r1, input logic [15:0] d1,
                            input bit du = 1'b0, input logic [3:0] r2 = 4'd0,
                            input logic [15:0] d2 = 16'd0);
    bus.pipe_valid = v;  bus.pipe_dual = du;
    bus.pipe_rd1 = r1;   bus.pipe_rd2 = r2;
    bus.pipe_data1 = d1; bus.pipe_data2 = d2;
  endtask

  task automatic drive_mdu(input bit v, input logic [3:0] r1, input logic [15:0] d1,
                           input bit du = 1'b0, input logic [3:0] r2 = 4'd0,
                           input logic [15:0] d2 = 16'd0);
    bus.mdu_valid = v;  bus.mdu_dual = du;
    bus.mdu_rd1 = r1;   bus.mdu_rd2 = r2;
    bus.mdu_data1 = d1; bus.mdu_data2 = d2;
  endtask

  task automatic drive_issue(input bit v, input bit du, input logic [3:0] r1, input logic [3:0] r2);
    bus.mdu_issue = v; bus.mdu_issue_dual = du;
    bus.mdu_issue_rd1 = r1; bus.mdu_issue_rd2 = r2;
  endtask

  task automatic push_exp(input bit du, input logic [3:0] r1, input logic [15:0] d1,
                          input logic [3:0] r2 = 4'd0, input logic [15:0] d2 = 16'd0);
    exp_t e;
    e.dual = du; e.rd1 = r1; e.rd2 = r2; e.d1 = d1; e.d2 = d2;
    exp_q.push_back(e);
  endtask

  // Write-port monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.reg_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'({bus.write_reg1, bus.write_data1}), 64'hDEAD_0000_0000);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_port1", 64'({bus.write_op2, bus.write_reg1, bus.write_data1}),
                64'({mon_e.dual, mon_e.rd1, mon_e.d1}));
          if (mon_e.dual)
            check("write_port2", 64'({bus.write_reg2, bus.write_data2}),
                  64'({mon_e.rd2, mon_e.d2}));
        end
      end else begin
        check("idle_op2", 64'(bus.write_op2), 64'(0));
      end
    end
  end

  bit starve_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int k;
    rst = 1'b0;
    drive_pipe(1'b1, 4'd3, 16'h1234);
    drive_mdu(1'b0, 4'd0, 16'd0);
    drive_issue(1'b0, 1'b0, 4'd0, 4'd0);

    // Reset held with pipe traffic present
    repeat (3) begin
      @(negedge clk);
      check("rst_pipe_ready", 64'(bus.pipe_ready), 64'(0));
      check("rst_reg_write", 64'(bus.reg_write), 64'(0));
      check("rst_pending", 64'(bus.pending_mask), 64'(0));
    end
    cyc();
    rst = 1'b1;
    push_exp(1'b0, 4'd3, 16'h1234);
    @(negedge clk);
    check("first_pipe_ready", 64'(bus.pipe_ready), 64'(1));
    cyc();
    drive_pipe(1'b0, 4'd0, 16'd0);
    @(negedge clk);
    check("first_latency", 64'({bus.reg_write, bus.write_reg1, bus.write_data1}),
          64'({1'b1, 4'd3, 16'h1234}));

    // Dual MDU result, no pipe traffic
    cyc();
    drive_issue(1'b1, 1'b1, 4'd4, 4'd5);
    cyc();
    drive_issue(1'b0, 1'b0, 4'd0, 4'd0);
    drive_mdu(1'b1, 4'd4, 16'hAAAA, 1'b1, 4'd5, 16'h5555);
    push_exp(1'b1, 4'd4, 16'hAAAA, 4'd5, 16'h5555);
    @(negedge clk);
    check("issue_pending", 64'(bus.pending_mask), 64'h0030);
    cyc();
    drive_mdu(1'b0, 4'd0, 16'd0);
    @(negedge clk);
    check("mdu_no_bypass", 64'(bus.reg_write), 64'(0));
    cyc();
    @(negedge clk);
    check("mdu_dual_pulse", 64'({bus.reg_write, bus.write_op2}), 64'(2'b11));
    check("pending_pre_commit", 64'(bus.pending_mask), 64'h0030);
    cyc();
    @(negedge clk);
    check("pending_post_commit", 64'(bus.pending_mask), 64'(0));

    // Starvation guard: one buffered MDU entry vs continuous pipe traffic
    k = 0;
    for (int c = 0; c < 7; c++) begin
      cyc();
      drive_pipe(1'b1, 4'(k + 1), 16'hB000 + 16'(k));
      if (c == 0) drive_mdu(1'b1, 4'd9, 16'h0909);
      else        drive_mdu(1'b0, 4'd0, 16'd0);
      if (starve_rdy[c]) push_exp(1'b0, 4'(k + 1), 16'hB000 + 16'(k));
      else               push_exp(1'b0, 4'd9, 16'h0909);
      @(negedge clk);
      check($sformatf("starve_ready_c%0d", c), 64'(bus.pipe_ready), 64'(starve_rdy[c]));
      if (starve_rdy[c]) k++;
    end
    cyc();
    drive_pipe(1'b0, 4'd0, 16'd0);

    // FIFO full: two results buffered behind pipe traffic, third held by source
    cyc();
    drive_pipe(1'b1, 4'd1, 16'hC100);
    drive_mdu(1'b1, 4'd10, 16'h1010);
    push_exp(1'b0, 4'd1, 16'hC100);
    @(negedge clk);
    check("full_ready_c0", 64'(bus.mdu_ready), 64'(1));
    cyc();
    drive_pipe(1'b1, 4'd2, 16'hC101);
    drive_mdu(1'b1, 4'd11, 16'h2020, 1'b1, 4'd11, 16'h2121);
    push_exp(1'b0, 4'd2, 16'hC101);
    @(negedge clk);
    check("full_ready_c1", 64'(bus.mdu_ready), 64'(1));
    cyc();
    drive_pipe(1'b1, 4'd3, 16'hC102);
    drive_mdu(1'b1, 4'd12, 16'h3030);
    push_exp(1'b0, 4'd3, 16'hC102);
    @(negedge clk);
    check("full_ready_c2", 64'(bus.mdu_ready), 64'(0));
    check("full_pipe_ready_c2", 64'(bus.pipe_ready), 64'(1));
    cyc();
    drive_pipe(1'b0, 4'd0, 16'd0);
    push_exp(1'b0, 4'd10, 16'h1010);
    @(negedge clk);
    check("full_ready_c3", 64'(bus.mdu_ready), 64'(0));
    cyc();
    push_exp(1'b1, 4'd11, 16'h2020, 4'd11, 16'h2121);
    @(negedge clk);
    check("full_ready_c4", 64'(bus.mdu_ready), 64'(1));
    cyc();
    drive_mdu(1'b0, 4'd0, 16'd0);
    push_exp(1'b0, 4'd12, 16'h3030);
    repeat (3) cyc();

    // Scoreboard collision on r7
    drive_issue(1'b1, 1'b0, 4'd7, 4'd0);
    cyc();
    drive_issue(1'b0, 1'b0, 4'd0, 4'd0);
    drive_mdu(1'b1, 4'd7, 16'h0707);
    push_exp(1'b0, 4'd7, 16'h0707);
    @(negedge clk);
    check("coll_pending_set", 64'(bus.pending_mask), 64'h0080);
    cyc();
    drive_mdu(1'b0, 4'd0, 16'd0);
    cyc();
    drive_issue(1'b1, 1'b0, 4'd7, 4'd0);
    @(negedge clk);
    check("coll_commit_cycle", 64'({bus.reg_write, bus.write_reg1}), 64'({1'b1, 4'd7}));
    cyc();
    drive_issue(1'b0, 1'b0, 4'd0, 4'd0);
    drive_mdu(1'b1, 4'd7, 16'h7777);
    push_exp(1'b0, 4'd7, 16'h7777);
    @(negedge clk);
    check("coll_set_wins", 64'(bus.pending_mask), 64'h0080);
    cyc();
    drive_mdu(1'b0, 4'd0, 16'd0);
    cyc();
    @(negedge clk);
    check("coll_still_pending", 64'(bus.pending_mask), 64'h0080);
    cyc();
    @(negedge clk);
    check("coll_cleared", 64'(bus.pending_mask), 64'(0));

    // Reset mid-operation with two buffered entries
    cyc();
    drive_issue(1'b1, 1'b1, 4'd0, 4'd7);
    cyc();
    drive_issue(1'b0, 1'b0, 4'd0, 4'd0);
    drive_pipe(1'b1, 4'd1, 16'hE000);
    drive_mdu(1'b1, 4'd0, 16'hDEAD);
    push_exp(1'b0, 4'd1, 16'hE000);
    @(negedge clk);
    check("mid_pending", 64'(bus.pending_mask), 64'h0081);
    cyc();
    drive_pipe(1'b1, 4'd2, 16'hE001);
    drive_mdu(1'b1, 4'd7, 16'hBEEF);
    push_exp(1'b0, 4'd2, 16'hE001);
    cyc();
    drive_pipe(1'b0, 4'd0, 16'd0);
    drive_mdu(1'b0, 4'd0, 16'd0);
    @(negedge clk);
    check("mid_full", 64'(bus.mdu_ready), 64'(0));
    check("mid_pending_pre_rst", 64'(bus.pending_mask), 64'h0081);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_pending", 64'(bus.pending_mask), 64'(0));
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_outputs", 64'({bus.reg_write, bus.write_op2, bus.pipe_ready, bus.mdu_ready}),
            64'(0));
    end
    cyc();
    rst = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    check("post_rst_pending", 64'(bus.pending_mask), 64'(0));
    check("post_rst_ready", 64'({bus.pipe_ready, bus.mdu_ready}), 64'(2'b11));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
